// File: rtl/uart_pkg.sv
// Shared constants, encodings and FSM state type for the configurable UART receiver.
package uart_pkg;

    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_FIFO   = 3'd5;
    localparam logic [2:0] ADDR_LEVEL  = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    localparam logic [1:0] PM_NONE = 2'b00;
    localparam logic [1:0] PM_EVEN = 2'b01;
    localparam logic [1:0] PM_ODD  = 2'b10;
    localparam logic [1:0] PM_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_PUSH
    } rx_state_e;

    // CTRL/STAT read-side bit positions
    localparam int CS_EN    = 0;
    localparam int CS_RDY   = 1;
    localparam int CS_OVR   = 2;
    localparam int CS_PM_LO = 3;
    localparam int CS_STOP2 = 5;
    localparam int CS_FULL  = 6;

    // CTRL write-side bit positions
    localparam int CW_EN    = 0;
    localparam int CW_PM_LO = 1;
    localparam int CW_STOP2 = 3;

    function automatic logic parity_on(input logic [1:0] pm);
        return (pm == PM_EVEN) || (pm == PM_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Host register bus plus the serial line of the UART receiver.
interface uart_rx_cfg_if ();

    logic       wren;
    logic       rden;
    logic [2:0] addr;
    logic [7:0] din;
    logic [9:0] dout;
    logic       rxin;

    modport master (
        output wren, rden, addr, din, rxin,
        input  dout
    );

    modport slave (
        input  wren, rden, addr, din, rxin,
        output dout
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with flush, fill level and full/empty flags.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wp_q, wp_d;
    logic [AW:0]      rp_q, rp_d;
    logic             do_push, do_pop;

    assign level = wp_q - rp_q;
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign dout  = mem_q[rp_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so push on full succeeds with it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (do_push) wp_d = wp_q + ONE;
            if (do_pop)  rp_d = rp_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wp_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: baud tick, majority-vote framing FSM,
// receive FIFO and a 3-bit address register bus.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  PERIOD_RST = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_cfg_if.slave bus
);

    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_W - 1);

    logic [7:0] period_q, period_d;
    logic       en_q, en_d;
    logic [1:0] pmode_q, pmode_d;
    logic       stop2_q, stop2_d;
    logic       ovr_q, ovr_d;
    logic [8:0] cnt_q, cnt_d;
    logic       s1_q, s2_q;

    rx_state_e  state_q, state_d;
    logic       armed_q, armed_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bitn_q, bitn_d;
    logic [7:0] sh_q, sh_d;
    logic [1:0] vote_q, vote_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic [1:0] cpm_q, cpm_d;
    logic       cs2_q, cs2_d;

    logic             wr_period, wr_ctrl, rd_fifo, flush;
    logic             tick, maj, exp_par;
    logic [1:0]       vsum;
    logic [7:0]       data8;
    logic             push, pop, overflow;
    logic [9:0]       fifo_dout, ctrl_rd, rdata;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full, fifo_empty;

    assign wr_period = bus.wren && (bus.addr == ADDR_PERIOD);
    assign wr_ctrl   = bus.wren && (bus.addr == ADDR_CTRL);
    assign rd_fifo   = bus.rden && (bus.addr == ADDR_FIFO);
    assign flush     = wr_ctrl && !bus.din[CW_EN];

    assign tick = en_q && (cnt_q == {period_q, 1'b1});

    // Third sample of the vote is the live line value at tick 9
    assign vsum    = vote_q + {1'b0, s2_q};
    assign maj     = vsum[1];
    assign data8   = sh_q >> (8 - DATA_W);
    assign exp_par = (^data8) ^ (cpm_q == PM_ODD);

    assign pop      = rd_fifo;
    assign push     = (state_q == ST_PUSH) && !flush;
    assign overflow = push && fifo_full && !(pop && !fifo_empty);

    always_comb begin
        period_d = period_q;
        en_d     = en_q;
        pmode_d  = pmode_q;
        stop2_d  = stop2_q;
        if (wr_period) period_d = bus.din;
        if (wr_ctrl) begin
            en_d    = bus.din[CW_EN];
            pmode_d = bus.din[CW_PM_LO +: 2];
            stop2_d = bus.din[CW_STOP2];
        end
        ovr_d = flush ? 1'b0 : (ovr_q | overflow);
        cnt_d = cnt_q;
        if (wr_period) cnt_d = '0;
        else if (en_q) cnt_d = tick ? '0 : cnt_q + 9'd1;
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        tcnt_d  = tcnt_q;
        bitn_d  = bitn_q;
        sh_d    = sh_q;
        vote_d  = vote_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        cpm_d   = cpm_q;
        cs2_d   = cs2_q;
        if (!en_q || flush) begin
            state_d = ST_IDLE;
            armed_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s2_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = ST_START;
                        tcnt_d  = '0;
                        bitn_d  = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        cpm_d   = pmode_q;
                        cs2_d   = stop2_q;
                    end
                end
                ST_PUSH: begin
                    state_d = ST_IDLE;
                    armed_d = 1'b0;
                end
                default: begin
                    if (tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd7) vote_d = {1'b0, s2_q};
                        if (tcnt_q == 4'd8) vote_d = vsum;
                        case (state_q)
                            ST_START: begin
                                if (tcnt_q == 4'd9 && maj) begin
                                    state_d = ST_IDLE;
                                    armed_d = 1'b0;
                                end else if (tcnt_q == 4'd15) begin
                                    state_d = ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (tcnt_q == 4'd9) sh_d = {maj, sh_q[7:1]};
                                if (tcnt_q == 4'd15) begin
                                    if (bitn_q == LAST_BIT)
                                        state_d = parity_on(cpm_q) ? ST_PARITY : ST_STOP1;
                                    else
                                        bitn_d = bitn_q + 3'd1;
                                end
                            end
                            ST_PARITY: begin
                                if (tcnt_q == 4'd9)  perr_d  = maj ^ exp_par;
                                if (tcnt_q == 4'd15) state_d = ST_STOP1;
                            end
                            ST_STOP1: begin
                                if (tcnt_q == 4'd9) begin
                                    ferr_d = !maj;
                                    if (!cs2_q) state_d = ST_PUSH;
                                end else if (tcnt_q == 4'd15) begin
                                    state_d = ST_STOP2;
                                end
                            end
                            ST_STOP2: begin
                                if (tcnt_q == 4'd9) begin
                                    ferr_d  = ferr_q | !maj;
                                    state_d = ST_PUSH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= PERIOD_RST;
            en_q     <= 1'b0;
            pmode_q  <= PM_NONE;
            stop2_q  <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            state_q  <= ST_IDLE;
            armed_q  <= 1'b0;
            tcnt_q   <= '0;
            bitn_q   <= '0;
            sh_q     <= '0;
            vote_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            cpm_q    <= PM_NONE;
            cs2_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            en_q     <= en_d;
            pmode_q  <= pmode_d;
            stop2_q  <= stop2_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
            s1_q     <= bus.rxin;
            s2_q     <= s1_q;
            state_q  <= state_d;
            armed_q  <= armed_d;
            tcnt_q   <= tcnt_d;
            bitn_q   <= bitn_d;
            sh_q     <= sh_d;
            vote_q   <= vote_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            cpm_q    <= cpm_d;
            cs2_q    <= cs2_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({perr_q, ferr_q, data8}),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CS_EN]         = en_q;
        ctrl_rd[CS_RDY]        = !fifo_empty;
        ctrl_rd[CS_OVR]        = ovr_q;
        ctrl_rd[CS_PM_LO +: 2] = pmode_q;
        ctrl_rd[CS_STOP2]      = stop2_q;
        ctrl_rd[CS_FULL]       = fifo_full;
    end

    always_comb begin
        rdata = '0;
        if (bus.rden) begin
            unique case (bus.addr)
                ADDR_PERIOD: rdata = {2'b00, period_q};
                ADDR_FIFO:   rdata = fifo_dout;
                ADDR_LEVEL:  rdata = 10'(fifo_level);
                ADDR_CTRL:   rdata = ctrl_rd;
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.dout = rdata;

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the lab UART receiver, with the same 3-bit address register bus.
Adds:
- configurable data width
- optional even/odd parity with a per-character parity-error flag
- one or two stop bits
- parametrised receive FIFO depth with a readable fill level
- 3-sample majority-vote bit sampling

Serial input is `rxin`. The host reads characters through the FIFO register.

Parameters:
DATA_W, 8, data bits per character; legal values 5..8; upper unused bits of returned data read 0
FIFO_DEPTH, 16, receive FIFO entries; power of two, 4..256
PERIOD_RST, 8'h00, reset value of the PERIOD register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wren  in  1  register write strobe, sampled on rising clk
rden  in  1  register read enable
addr  in  3  register address
din  in  8  write data
dout  out  10  read data; combinational mux of the addressed register, 0 when rden=0
rxin  in  1  asynchronous serial line, idle high

Behaviour:
Register map:
- 4 PERIOD: R/W 8 bits.
- 5 FIFO: read-only. dout = {perr, ferr, data zero-extended to 8}.
- 6 LEVEL: read-only. Entry count, zero-extended.
- 7 CTRL/STAT:
  - Write fields: din[0]=EN, din[2:1]=PMODE (00 none, 01 even, 10 odd, 11 reserved = none), din[3]=STOP2.
  - Read fields: [0]=EN, [1]=DATARDY (FIFO not empty), [2]=OVERRUN, [4:3]=PMODE, [5]=STOP2, [6]=FULL, others 0.

Reset:
- PERIOD=PERIOD_RST; EN, PMODE, STOP2, OVERRUN = 0.
- FIFO empty; FSM in IDLE; dout=0.

Baud tick:
- One-clock 16x enable every 2*(PERIOD+1) clocks.
- Tick counter runs only while EN=1 and reloads on any PERIOD write.

Input path:
- rxin passes through a 2-flop synchroniser.
- Each bit value is the majority of samples at ticks 7, 8 and 9 of the bit.

FSM states:
- IDLE: arms only after the synchronised line has been seen high. A high-to-low transition moves to START and zeroes the tick count.
- START: evaluates the start bit at tick 9. A majority of 1 is a false start: return to IDLE, no FIFO entry. A majority of 0 goes to DATA.
- DATA: DATA_W bits, LSB first, 16 ticks each.
- PARITY: present only when PMODE is even or odd. perr=1 if the received bit mismatches the computed parity.
- STOP1: ferr=1 if the majority is 0. If STOP2=1, go to STOP2 and OR its check into ferr.
- PUSH: one clock. Writes {perr, ferr, data}, then returns to IDLE.
- After a framing error the FSM re-arms only once the line has returned high (break tolerance).

FIFO:
- Push at PUSH when not full.
- If full at PUSH, the character is discarded and OVERRUN sets. OVERRUN is sticky.
- Pop on any rising edge with rden=1, addr=5 and not empty. dout shows the head entry combinationally before that edge.
- Simultaneous push and pop on a full FIFO: pop first, so the push succeeds and there is no overrun.
- Pop when empty: no effect; the returned value is undefined but must not corrupt state.

EN=0 write:
- FSM forced to IDLE; partial character discarded.
- FIFO flushed; OVERRUN cleared; tick counter held.
- Effective on the edge after the write.
- PMODE/STOP2 changes while a character is in flight take effect at the next START.

Latency:
- DATARDY rises 1 clock after the PUSH state.
- PUSH occurs 1 clock after the final stop-sample tick.

Decomposition:
- Package uart_pkg:
  - address constants ADDR_PERIOD=4, ADDR_FIFO=5, ADDR_LEVEL=6, ADDR_CTRL=7
  - PMODE encodings
  - state enum for IDLE/START/DATA/PARITY/STOP1/STOP2/PUSH
  - CTRL/STAT bit index constants
- Sub-module uart_rx_fifo:
  - synchronous FIFO, parameters WIDTH (= 10) and DEPTH
  - ports: push, pop, flush, dout, level, full, empty
  - asynchronous reset

Test Plan:
1. PERIOD=8'h0C, EN=1, PMODE=00, DATA_W=8, 8N1 frame 8'h39 -> DATARDY=1, FIFO read = 10'h039, LEVEL returns 0 after pop.
2. Frames 8'h12, 8'hD3, 8'hB7 back to back without reads -> LEVEL=3; three reads return 10'h012, 10'h0D3, 10'h0B7 in order.
3. Bad stop bit on 8'h55 -> entry 10'h155. Line then held low for two character times before 8'h84 -> only one bad entry, then 10'h084.
4. 2-tick start glitch (low 2 ticks, then high) followed by 8'hAA -> exactly one entry 10'h0AA.
5. PMODE=01 (even), frame 8'h03 with parity bit 1 -> entry 10'h203. Same frame with parity 0 -> 10'h003. STOP2=1, second stop low -> ferr set.
6. 17 frames with no reads -> after 16 OVERRUN=0, FULL=1; 17th sets OVERRUN=1, LEVEL=16. Write EN=0 -> OVERRUN=0, DATARDY=0. Write EN=1, send 8'hA7 -> read 10'h0A7. Assert reset mid-frame -> all outputs at reset values.
